spi_rom_fetch: RTL
==================

// Module: spi_rom_fetch
// PURPOSE
//  Upstream SPI flash read master feeding the VGA display path. On each request it
//  issues READ (03h) plus a 24-bit address, then streams len bytes of MISO data out
//  as bytes with one-cycle valid strobes, for consumption by a line buffer/painter.
//  It replaces free-running ~clk SCLK with a registered clk/2 SCLK (SPI mode 0).
// PARAMETERS
//  CMD_READ  8'h03  command byte shifted first, MSB first
//  LEN_W     5      width of len input; max transfer 2**LEN_W-1 bytes
//  CS_GAP    4      min clk cycles spi_cs held low between transactions (>=1)
// PORTS
//  clk        in   1      system/pixel clock
//  reset_n    in   1      asynchronous, active-low reset
//  req        in   1      start request; sampled only in IDLE
//  addr       in   24     start byte address, captured when req accepted
//  len        in   LEN_W  bytes to read, captured when req accepted; 0 = no SPI cycle
//  abort      in   1      terminate current transaction at next clk
//  busy       out  1      high from accept until end of CS_GAP
//  byte_valid out  1      one-cycle strobe: byte_data valid
//  byte_data  out  8      received byte, MSB = first bit received
//  done       out  1      one-cycle strobe when last byte delivered or abort completes
//  spi_cs     out  1      chip select, ACTIVE HIGH (board inverts)
//  spi_sclk   out  1      registered SCLK, idle low
//  spi_mosi   out  1      master data out
//  spi_miso   in   1      slave data in
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; shift/bit/byte counters 0.
//  - States: IDLE -> CMD (8b) -> ADDR (24b) -> DATA (len*8 b) -> GAP (CS_GAP clk) -> IDLE.
//  - Accept: req=1 in IDLE with len!=0 -> next clk spi_cs=1, busy=1, MOSI=CMD[7].
//    len==0: no CS assertion; done strobes 1 clk after accept, busy never rises.
//  - Bit timing: 2 clk per bit. Phase0 SCLK=0 (MOSI set), phase1 SCLK=1. MISO sampled
//    on clk edge ending phase1 (SCLK 1->0). MOSI changes only on SCLK falling/phase0.
//  - First SCLK rise occurs 1 clk after spi_cs rises (setup margin).
//  - Preamble = 32 bits = 64 clk; MOSI forced 0 during DATA and GAP.
//  - byte_valid asserted the clk after the 8th bit of a byte is sampled; byte_data held
//    until next byte. No backpressure: consumer must take every strobe.
//  - After last data bit: SCLK stays 0, spi_cs drops next clk, done=1 same clk as final
//    byte_valid, then GAP for CS_GAP clk, busy falls on GAP exit.
//  - req while busy: ignored (not queued). req and done same clk: ignored.
//  - abort (any non-IDLE state except GAP): next clk spi_cs=0, SCLK=0, MOSI=0, partial
//    byte discarded (no byte_valid), done=1, enter GAP. abort in GAP/IDLE: no effect.
//  - Counters: bit counter 5b within a byte/field, byte counter LEN_W b, no wrap;
//    address not incremented internally (flash auto-increments).
//  - Async reset mid-transfer: spi_cs drops immediately (combinationally via reset).
// STRUCTURE
//  - Shared package/header: state encodings, CMD_READ, SPI field lengths (8/24).
//  - One natural sub-module: spi_shift_phy (SCLK phase, MOSI shifter, MISO sampler);
//    FSM and counters in spi_rom_fetch.
// TESTING (flash behavioural model, mode 0)
//  - addr=000010h, len=1, model byte A5h -> MOSI 03 00 00 10; byte_valid once, A5h;
//    spi_cs high exactly 64+16+1 clk; done same clk as byte_valid.
//  - len=16 from 000000h, data 00..0Fh -> 16 strobes 16 clk apart, values 00h..0Fh.
//  - len=0 with req -> no spi_cs pulse, done 1 clk after accept, busy stays 0.
//  - abort at clk 70 of len=4 -> spi_cs low next clk, no byte_valid, done=1, busy low
//    CS_GAP clk later; immediate new req accepted only after busy low.
//  - req pulsed during transfer -> ignored; exactly one transaction on bus.
//  - reset_n low mid-DATA -> all outputs 0 asynchronously; after release, IDLE, new req ok.

Source files
------------

// File: rtl/spi_rom_fetch_pkg.sv
// Shared definitions for the SPI flash read master: FSM states, opcode and
// SPI field lengths.
package spi_rom_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } fetch_state_e;

  localparam logic [7:0] CMD_READ_DEF = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int BYTE_BITS = 8;
  localparam int PRE_BITS  = CMD_BITS + ADDR_BITS;
  localparam int BIT_CNT_W = 5;

  // Bit counters run down to zero, so a field of n bits loads n-1.
  function automatic logic [BIT_CNT_W-1:0] field_last(input int nbits);
    return BIT_CNT_W'(nbits - 1);
  endfunction

  function automatic logic [PRE_BITS-1:0] preamble(input logic [CMD_BITS-1:0]  cmd,
                                                   input logic [ADDR_BITS-1:0] addr);
    return {cmd, addr};
  endfunction

endpackage

// File: rtl/spi_rom_fetch_if.sv
// Request/byte-stream bus between the display path and the SPI flash read master.
interface spi_rom_fetch_if
  import spi_rom_fetch_pkg::*;
#(
  parameter int LEN_W = 5
);

  logic                 req;
  logic [ADDR_BITS-1:0] addr;
  logic [LEN_W-1:0]     len;
  logic                 abort;
  logic                 busy;
  logic                 byte_valid;
  logic [BYTE_BITS-1:0] byte_data;
  logic                 done;

  modport master (
    output req, addr, len, abort,
    input  busy, byte_valid, byte_data, done
  );

  modport slave (
    input  req, addr, len, abort,
    output busy, byte_valid, byte_data, done
  );

endinterface

// File: rtl/spi_rom_fetch_shift_phy.sv
// SPI mode-0 bit engine: registered clk/2 SCLK, MSB-first MOSI shifter and
// MISO sampler. The FSM decides when it loads, shifts or halts.
module spi_shift_phy
  import spi_rom_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 halt,
  input  logic [PRE_BITS-1:0]  tx_word,
  input  logic                 spi_miso,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic [BYTE_BITS-1:0] rx_byte
);

  logic [PRE_BITS-1:0] tx_sr;

  // A shift with SCLK high ends the bit: SCLK falls, MISO is taken and the next
  // MOSI bit is presented. Once the preamble is out tx_sr is all zeros, which
  // keeps MOSI low for the data phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sr    <= '0;
      rx_byte  <= '0;
    end else if (halt) begin
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      tx_sr    <= '0;
    end else if (load) begin
      spi_sclk <= 1'b0;
      spi_mosi <= tx_word[PRE_BITS-1];
      tx_sr    <= {tx_word[PRE_BITS-2:0], 1'b0};
    end else if (shift) begin
      if (!spi_sclk) begin
        spi_sclk <= 1'b1;
      end else begin
        spi_sclk <= 1'b0;
        spi_mosi <= tx_sr[PRE_BITS-1];
        tx_sr    <= {tx_sr[PRE_BITS-2:0], 1'b0};
        rx_byte  <= {rx_byte[BYTE_BITS-2:0], spi_miso};
      end
    end
  end

endmodule

// File: rtl/spi_rom_fetch.sv
// SPI flash READ master: issues opcode + 24-bit address, then streams len bytes
// out as one-cycle strobes for the display line buffer.
//
// state   | meaning
// IDLE    | waiting for req; len==0 answers with done only
// CMD     | shifting the 8-bit read opcode
// ADDR    | shifting the 24-bit start address
// DATA    | receiving bytes; bytes_left==0 is the CS release cycle
// GAP     | CS low recovery time before the next request
module spi_rom_fetch
  import spi_rom_fetch_pkg::*;
#(
  parameter logic [7:0] CMD_READ = CMD_READ_DEF,
  parameter int         LEN_W    = 5,
  parameter int         CS_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_rom_fetch_if.slave        bus,
  output logic                  spi_cs,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

  fetch_state_e state_q, state_d;

  logic [BIT_CNT_W-1:0] bit_left_q, bit_left_d;
  logic [LEN_W-1:0]     bytes_left_q, bytes_left_d;
  logic [GAP_W-1:0]     gap_left_q, gap_left_d;
  logic                 cs_q, cs_d;
  logic                 done_q, done_d;
  logic                 byte_rdy_q, byte_rdy_d;
  logic                 byte_valid_q;
  logic [BYTE_BITS-1:0] byte_data_q;

  logic                 phy_load;
  logic                 phy_shift;
  logic                 phy_halt;
  logic [BYTE_BITS-1:0] rx_byte;
  logic                 sclk_w;
  logic                 mosi_w;

  spi_shift_phy u_phy (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (phy_load),
    .shift    (phy_shift),
    .halt     (phy_halt),
    .tx_word  (preamble(CMD_READ, bus.addr)),
    .spi_miso (spi_miso),
    .spi_sclk (sclk_w),
    .spi_mosi (mosi_w),
    .rx_byte  (rx_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_left_q   <= '0;
      bytes_left_q <= '0;
      gap_left_q   <= '0;
      cs_q         <= 1'b0;
      done_q       <= 1'b0;
      byte_rdy_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_left_q   <= bit_left_d;
      bytes_left_q <= bytes_left_d;
      gap_left_q   <= gap_left_d;
      cs_q         <= cs_d;
      done_q       <= done_d;
      byte_rdy_q   <= byte_rdy_d;
      byte_valid_q <= byte_rdy_q;
      if (byte_rdy_q) byte_data_q <= rx_byte;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_left_d   = bit_left_q;
    bytes_left_d = bytes_left_q;
    gap_left_d   = gap_left_q;
    cs_d         = cs_q;
    done_d       = 1'b0;
    byte_rdy_d   = 1'b0;
    phy_load     = 1'b0;
    phy_shift    = 1'b0;
    phy_halt     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_q blocks a req that coincides with a zero-length completion.
        if (bus.req && !done_q) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_CMD;
            cs_d         = 1'b1;
            phy_load     = 1'b1;
            bit_left_d   = field_last(CMD_BITS);
            bytes_left_d = bus.len;
          end
        end
      end

      ST_CMD, ST_ADDR, ST_DATA: begin
        if (bus.abort || (state_q == ST_DATA && bytes_left_q == '0)) begin
          state_d    = ST_GAP;
          cs_d       = 1'b0;
          done_d     = 1'b1;
          phy_halt   = 1'b1;
          gap_left_d = GAP_LOAD;
        end else begin
          phy_shift = 1'b1;
          if (sclk_w) begin
            if (bit_left_q != '0) begin
              bit_left_d = bit_left_q - 1'b1;
            end else if (state_q == ST_CMD) begin
              state_d    = ST_ADDR;
              bit_left_d = field_last(ADDR_BITS);
            end else if (state_q == ST_ADDR) begin
              state_d    = ST_DATA;
              bit_left_d = field_last(BYTE_BITS);
            end else begin
              byte_rdy_d   = 1'b1;
              bytes_left_d = bytes_left_q - 1'b1;
              bit_left_d   = field_last(BYTE_BITS);
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_left_q == '0) state_d = ST_IDLE;
        else gap_left_d = gap_left_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_cs         = cs_q;
  assign spi_sclk       = sclk_w;
  assign spi_mosi       = mosi_w;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;

endmodule
